// File: rtl/uart_rx_deserializer.sv
// UART receive front end: rx synchroniser, 16x oversampling with a 3-sample majority vote,
// 8N1 deframing, and a one-entry valid/ready output register with ferr/brk/overrun status.
module uart_rx_deserializer #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_ferr,
  output logic             rx_brk,
  output logic             overrun,
  output logic             busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [1:0]             state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             scnt_q, scnt_d;
  logic [2:0]             bidx_q, bidx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   s7_q, s7_d;
  logic                   s8_q, s8_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_ferr_q, rx_ferr_d;
  logic                   rx_brk_q, rx_brk_d;
  logic                   overrun_q, overrun_d;

  logic rx_s, fall, tick, mid, last, vote, emit;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
    rx_s      = sync_q[SYNC_STAGES-1];
    rx_prev_d = rx_s;
    fall      = rx_prev_q & ~rx_s;

    // Counter is held at 0 while idle so the tick phase starts at the start edge.
    tick = en && (state_q != StIdle) && (cnt_q == baud_div);
    if (!en || (state_q == StIdle) || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    mid  = tick && (scnt_q == 4'd9);
    last = tick && (scnt_q == 4'd15);
    vote = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);

    s7_d    = (tick && (scnt_q == 4'd7)) ? rx_s : s7_q;
    s8_d    = (tick && (scnt_q == 4'd8)) ? rx_s : s8_q;
    scnt_d  = tick ? scnt_q + 4'd1 : scnt_q;
    state_d = state_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    emit    = 1'b0;

    if (!en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (fall) begin
            state_d = StStart;
            scnt_d  = 4'd0;
          end
        end
        StStart: begin
          if (mid && vote) begin
            state_d = StIdle;
          end else if (last) begin
            state_d = StData;
            bidx_d  = 3'd0;
          end
        end
        StData: begin
          if (mid) begin
            shift_d = {vote, shift_q[7:1]};
          end
          if (last) begin
            if (bidx_q == 3'd7) begin
              state_d = StStop;
            end else begin
              bidx_d = bidx_q + 3'd1;
            end
          end
        end
        StStop: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (mid) begin
            emit    = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ferr_d  = rx_ferr_q;
    rx_brk_d   = rx_brk_q;
    overrun_d  = 1'b0;
    if (emit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_ferr_d  = ~vote;
        rx_brk_d   = ~vote & (shift_q == 8'h00);
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      scnt_q     <= 4'd0;
      bidx_q     <= 3'd0;
      shift_q    <= 8'h00;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_brk_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scnt_q     <= scnt_d;
      bidx_q     <= bidx_d;
      shift_q    <= shift_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_brk_q   <= rx_brk_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_ferr  = rx_ferr_q;
  assign rx_brk   = rx_brk_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at baud_div=26 (432 clocks per bit).
module tb_uart_rx_deserializer;

  localparam int BIT = 432;

  logic        clk = 1'b0;
  logic        rst, rx, en, rx_ready;
  logic [15:0] baud_div;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferr, rx_brk, overrun, busy;

  int n_checks = 0;
  int n_err    = 0;

  // Observation counters, sampled on the falling edge.
  int       n_acc = 0, n_ovr = 0, n_vcyc = 0, n_busy = 0;
  logic [7:0] acc_data = 8'h00;
  logic     acc_ferr = 1'b0, acc_brk = 1'b0;

  uart_rx_deserializer #(.DIV_W(16), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .en       (en),
    .baud_div (baud_div),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_ferr  (rx_ferr),
    .rx_brk   (rx_brk),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      n_acc    <= n_acc + 1;
      acc_data <= rx_data;
      acc_ferr <= rx_ferr;
      acc_brk  <= rx_brk;
    end
    if (overrun)  n_ovr  <= n_ovr + 1;
    if (rx_valid) n_vcyc <= n_vcyc + 1;
    if (busy)     n_busy <= n_busy + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(BIT);
    end
    rx = stop;
    step(BIT);
    rx = 1'b1;
  endtask

  int a0, o0, v0, b0;

  initial begin
    rst = 1'b1; rx = 1'b1; en = 1'b0; rx_ready = 1'b0; baud_div = 16'd26;
    step(3);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr_brk_ovr", {rx_ferr, rx_brk, overrun}, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; en = 1'b1;
    step(5);

    // Nominal byte with ready held high
    rx_ready = 1'b1;
    a0 = n_acc; o0 = n_ovr; v0 = n_vcyc;
    send_frame(8'hA5, 1'b1);
    step(2 * BIT);
    check("nom_count", n_acc - a0, 1);
    check("nom_data", acc_data, 8'hA5);
    check("nom_ferr_brk", {acc_ferr, acc_brk}, 0);
    check("nom_pulse", n_vcyc - v0, 1);
    check("nom_ovr", n_ovr - o0, 0);

    // Back-to-back with backpressure
    rx_ready = 1'b0;
    a0 = n_acc; o0 = n_ovr;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    step(2 * BIT);
    check("bp_valid", rx_valid, 1);
    check("bp_data", rx_data, 8'h3C);
    check("bp_ovr", n_ovr - o0, 1);
    check("bp_noacc", n_acc - a0, 0);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(1);
    check("bp_drain", rx_valid, 0);
    check("bp_drain_data", acc_data, 8'h3C);

    // Accept and emit on the same clock: emit commits 4161 clocks after the start edge
    send_frame(8'h3C, 1'b1);
    step(BIT);
    check("sim_held", rx_data, 8'h3C);
    a0 = n_acc; o0 = n_ovr;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        step(4160);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
      end
    join
    step(2 * BIT);
    check("sim_ovr", n_ovr - o0, 0);
    check("sim_acc", n_acc - a0, 1);
    check("sim_valid", rx_valid, 1);
    check("sim_data", rx_data, 8'hC3);
    rx_ready = 1'b1;
    step(2);

    // Framing error
    a0 = n_acc;
    send_frame(8'h55, 1'b0);
    step(2 * BIT);
    check("ferr_count", n_acc - a0, 1);
    check("ferr_data", acc_data, 8'h55);
    check("ferr_flags", {acc_ferr, acc_brk}, 2'b10);

    // Break: 12 bit times low
    a0 = n_acc;
    rx = 1'b0;
    step(12 * BIT);
    check("brk_count", n_acc - a0, 1);
    check("brk_data", acc_data, 8'h00);
    check("brk_flags", {acc_ferr, acc_brk}, 2'b11);
    check("brk_idle", busy, 0);
    rx = 1'b1;
    step(2 * BIT);
    check("brk_nomore", n_acc - a0, 1);

    // Glitch: 81 clocks low, START lasts 10 ticks of 27 clocks
    a0 = n_acc; b0 = n_busy; v0 = n_vcyc;
    rx = 1'b0;
    step(81);
    rx = 1'b1;
    step(3 * BIT);
    check("gl_busy_cycles", n_busy - b0, 270);
    check("gl_novalid", n_vcyc - v0, 0);
    check("gl_idle", busy, 0);

    // Abort with en=0 during data bit 4
    a0 = n_acc;
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      step(BIT);
    end
    rx = 1'b1;
    step(BIT / 2);
    en = 1'b0;
    step(1);
    check("ab_idle", busy, 0);
    step(BIT);
    en = 1'b1;
    step(BIT);
    check("ab_nobyte", n_acc - a0, 0);
    send_frame(8'h81, 1'b1);
    step(2 * BIT);
    check("ab_count", n_acc - a0, 1);
    check("ab_data", acc_data, 8'h81);
    check("ab_flags", {acc_ferr, acc_brk}, 0);

    // Reset mid-frame with a held byte
    rx_ready = 1'b0;
    send_frame(8'h7E, 1'b1);
    step(BIT);
    check("rs_held", rx_data, 8'h7E);
    rx = 1'b0;
    step(BIT);
    rx = 1'b0;
    step(3 * BIT);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rs_data", rx_data, 0);
    check("rs_valid", rx_valid, 0);
    check("rs_flags", {rx_ferr, rx_brk, overrun}, 0);
    check("rs_busy", busy, 0);
    rx = 1'b1;
    rx_ready = 1'b1;
    a0 = n_acc;
    step(7 * BIT);
    check("rs_nobyte", n_acc - a0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive front end of the UART unit behind the Avalon-MM UART interface.
- Synchronises the asynchronous rx pin and samples it at 16x baud with a 3-sample majority vote.
- Deframes 8N1 characters and presents each byte on a valid/ready port to the unit's RX buffer.
- Reports framing errors, overruns and line breaks per byte, for the status register and irq logic.

Parameters:
- DIV_W, 16, width of the oversample divisor input.
- SYNC_STAGES, 2, flip-flops in the rx input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idle high.
- en  in  1  receiver enable; 0 forces IDLE and discards any partial byte.
- baud_div  in  DIV_W  oversample tick period minus 1 (tick every baud_div+1 clocks).
- rx_data  out  8  received byte, LSB first on the wire.
- rx_valid  out  1  rx_data/rx_ferr/rx_brk hold a byte not yet consumed.
- rx_ready  in  1  consumer accepts the byte when rx_valid & rx_ready.
- rx_ferr  out  1  framing error for the presented byte (stop sample = 0).
- rx_brk  out  1  break: data all 0 and stop sample = 0.
- overrun  out  1  one-clock pulse: byte completed while rx_valid=1 and rx_ready=0.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: rx_data=0, rx_valid=0, rx_ferr=0, rx_brk=0, overrun=0, busy=0, state=IDLE. The synchroniser presets to 1 (idle line). The tick counter clears.
- Tick generator: the counter counts 0..baud_div and emits tick on the clock where the count equals baud_div, then wraps to 0.
  - baud_div=0 gives a tick every clock.
  - The counter resets to 0 whenever en=0 or the state is IDLE, so tick phase aligns to the start edge.
- Sample counter: scnt is 4 bits and advances on each tick. The sampled bit is the majority of the synchronised rx at scnt=7, 8, 9. It is committed at scnt=9, or at scnt=15 for the end of a bit period.
- FSM:
  - IDLE: on a synchronised rx falling edge (1 to 0) with en=1, go to START with scnt=0.
  - START: at scnt=9 majority, if the vote is 1 (glitch), return to IDLE with nothing emitted. Otherwise at scnt=15 go to DATA with bit index 0.
  - DATA: at scnt=9 shift the vote into the shift register MSB (right-shift, LSB first). At scnt=15, if index=7 go to STOP, else increment index.
  - STOP: at scnt=9, evaluate stop=vote, emit the byte (see output rules), and go to IDLE immediately. Going to IDLE at mid-stop allows back-to-back frames.
  - If the line stays low after a break, IDLE waits for rx=1 before arming again. The falling-edge detector only re-arms after a 1 is seen.
- Output register:
  - On emit, if rx_valid=0, or rx_valid=1 and rx_ready=1 in the same clock, load rx_data, rx_ferr=~stop, and rx_brk=(~stop & shift==0), then set rx_valid=1.
  - On emit with rx_valid=1 and rx_ready=0, the new byte is dropped, the held byte is unchanged, and overrun pulses for 1 clock.
  - With no emit, rx_valid & rx_ready clears rx_valid. rx_data holds its last value.
  - Latency: rx_valid rises 1 clock after the stop-bit mid-sample tick, which is the tick plus the 2-cycle synchroniser delay from the line.
- en=0 mid-frame: abort to IDLE on the next clock. Output register and rx_valid are unaffected.
- rst mid-frame: all state is cleared and the partial byte is lost.
- baud_div changes are only guaranteed correct while busy=0.

Test Plan:
- Nominal byte: baud_div=26 (27 clk/tick, 432 clk/bit), send 0xA5 8N1 with rx_ready=1. Required: rx_valid 1-clock pulse, rx_data=0xA5, rx_ferr=0, rx_brk=0, overrun=0.
- Back-to-back with backpressure: send 0x3C then 0xC3 with no idle gap, holding rx_ready=0. Required: rx_data stays 0x3C and overrun pulses once at the second stop mid-sample. After rx_ready=1, rx_valid falls.
- Simultaneous accept and emit: raise rx_ready on the exact clock of the second emit. Required: no overrun, and rx_data=0xC3 with rx_valid held 1.
- Framing and break:
  - Send 0x55 with stop=0. Required: rx_ferr=1, rx_brk=0.
  - Hold rx low for 12 bit times. Required: exactly one byte 0x00 with rx_ferr=1 and rx_brk=1, and no further byte until rx returns high and a new start arrives.
- Glitch rejection: drive rx low for 3 bit/16 periods (81 clocks) then high. Required: return to IDLE, no rx_valid, busy high only during START.
- Abort and reset: drop en at DATA bit 4, then send 0x81 with en=1; separately pulse rst mid-frame. Required: no partial byte emitted, 0x81 then received correctly, and all outputs 0 the clock after rst.
